// File: rtl/bash_round_ctrl.sv
// bash_round_ctrl: game-round controller for the whack-a-box game.
// Takes a random box number (2..5) from the box selector and lights it for a
// fixed hit window. It judges player hits, keeps score and lives, and then
// blanks the display for a gap before the next round.
//
// Ports:
//   CLOCK_50      in   system clock, rising edge
//   reset_signal  in   asynchronous active-high reset
//   start         in   pulse; starts or restarts a game (IDLE/OVER only)
//   box_valid     in   strobe; box_in carries a new random box
//   box_in        in   random box number, valid codes 2..5
//   hit_valid     in   strobe; player struck hit_box
//   hit_box       in   struck box number
//   active_box    out  box to draw, 0 = none lit
//   score         out  hits this game (saturating)
//   lives         out  remaining lives
//   hit_ok        out  one-cycle pulse on a correct hit
//   miss          out  one-cycle pulse on a wrong hit or timeout
//   game_over     out  high while in OVER
//   busy          out  high in WAIT_BOX, SHOW or GAP
module bash_round_ctrl #(
    parameter int WINDOW_CYCLES = 37500000,
    parameter int GAP_CYCLES    = 12500000,
    parameter int START_LIVES   = 3,
    parameter int SCORE_W       = 8
) (
    input  logic               CLOCK_50,
    input  logic               reset_signal,
    input  logic               start,
    input  logic               box_valid,
    input  logic [2:0]         box_in,
    input  logic               hit_valid,
    input  logic [2:0]         hit_box,
    output logic [2:0]         active_box,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               hit_ok,
    output logic               miss,
    output logic               game_over,
    output logic               busy
);

    localparam int TMAX = (WINDOW_CYCLES > GAP_CYCLES) ? WINDOW_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SHOW, S_GAP, S_OVER} state_t;

    state_t             r_state, w_state_n;
    logic [TW-1:0]      r_timer, w_timer_n;
    logic [2:0]         r_box, w_box_n;
    logic [SCORE_W-1:0] r_score, w_score_n;
    logic [1:0]         r_lives, w_lives_n;
    logic               w_hit_ok_n, w_miss_n;

    logic               w_box_ok, w_hit_good, w_expire;
    logic [1:0]         w_lives_dec;

    assign w_box_ok    = box_valid && (box_in >= 3'd2) && (box_in <= 3'd5);
    assign w_hit_good  = hit_valid && (hit_box == r_box);
    assign w_expire    = (r_timer == '0);
    // Lives never wrap below zero.
    assign w_lives_dec = (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;

    // State register
    always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
        if (reset_signal) r_state <= S_IDLE;
        else              r_state <= w_state_n;
    end

    // Next-state logic. A hit strobe outranks timer expiry, so a correct hit
    // landing on the last window cycle still counts as a hit.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_n = S_WAIT;
            S_WAIT:  if (w_box_ok) w_state_n = S_SHOW;
            S_SHOW: begin
                if (w_hit_good)
                    w_state_n = S_GAP;
                else if (hit_valid || w_expire)
                    w_state_n = (w_lives_dec != 2'd0) ? S_GAP : S_OVER;
            end
            S_GAP:   if (w_expire) w_state_n = S_WAIT;
            S_OVER:  if (start) w_state_n = S_WAIT;
            default: w_state_n = S_IDLE;
        endcase
    end

    // Next values of the datapath and pulse outputs
    always_comb begin
        w_timer_n  = r_timer;
        w_box_n    = r_box;
        w_score_n  = r_score;
        w_lives_n  = r_lives;
        w_hit_ok_n = 1'b0;
        w_miss_n   = 1'b0;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    w_score_n = '0;
                    w_lives_n = 2'(START_LIVES);
                end
            end
            S_WAIT: begin
                if (w_box_ok) begin
                    w_box_n   = box_in;
                    w_timer_n = TW'(WINDOW_CYCLES - 1);
                end
            end
            S_SHOW: begin
                if (w_hit_good) begin
                    w_hit_ok_n = 1'b1;
                    if (r_score != {SCORE_W{1'b1}})
                        w_score_n = r_score + SCORE_W'(1);
                end else if (hit_valid || w_expire) begin
                    w_miss_n  = 1'b1;
                    w_lives_n = w_lives_dec;
                end
                if (w_state_n == S_GAP)       w_timer_n = TW'(GAP_CYCLES - 1);
                else if (w_state_n == S_OVER) w_timer_n = '0;
                else                          w_timer_n = r_timer - TW'(1);
            end
            S_GAP: begin
                if (!w_expire) w_timer_n = r_timer - TW'(1);
            end
            default: ;
        endcase
    end

    // Datapath and output registers; level outputs follow the next state so
    // they change on the same edge as the state does.
    always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
        if (reset_signal) begin
            r_timer    <= '0;
            r_box      <= 3'd0;
            r_score    <= '0;
            r_lives    <= 2'd0;
            active_box <= 3'd0;
            hit_ok     <= 1'b0;
            miss       <= 1'b0;
            game_over  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_timer    <= w_timer_n;
            r_box      <= w_box_n;
            r_score    <= w_score_n;
            r_lives    <= w_lives_n;
            active_box <= (w_state_n == S_SHOW) ? w_box_n : 3'd0;
            hit_ok     <= w_hit_ok_n;
            miss       <= w_miss_n;
            game_over  <= (w_state_n == S_OVER);
            busy       <= (w_state_n == S_WAIT) || (w_state_n == S_SHOW) ||
                          (w_state_n == S_GAP);
        end
    end

    assign score = r_score;
    assign lives = r_lives;

endmodule

// File: tb/tb_bash_round_ctrl.sv
// Directed bench for bash_round_ctrl. hit_ok/miss events are checked against
// an expectation queue by a monitor; level outputs are checked inline.
module tb_bash_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, box_valid, hit_valid;
    logic [2:0] box_in, hit_box;
    logic [2:0] active_box;
    logic [7:0] score;
    logic [1:0] lives;
    logic       hit_ok, miss, game_over, busy;

    bash_round_ctrl #(
        .WINDOW_CYCLES(8), .GAP_CYCLES(4), .START_LIVES(3), .SCORE_W(8)
    ) dut (
        .CLOCK_50(clk), .reset_signal(rst), .start(start),
        .box_valid(box_valid), .box_in(box_in),
        .hit_valid(hit_valid), .hit_box(hit_box),
        .active_box(active_box), .score(score), .lives(lives),
        .hit_ok(hit_ok), .miss(miss), .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_hit;
        logic [7:0] score;
        logic [1:0] lives;
        logic       go;
    } ev_t;

    ev_t q[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic expect_ev(input logic h, input int s, input int l, input logic g);
        ev_t e;
        e.is_hit = h; e.score = 8'(s); e.lives = 2'(l); e.go = g;
        q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic give_box(input logic [2:0] b);
        box_valid = 1'b1; box_in = b;
        cyc(1);
        box_valid = 1'b0;
    endtask

    task automatic give_hit(input logic [2:0] b);
        hit_valid = 1'b1; hit_box = b;
        cyc(1);
        hit_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // Monitor: every hit_ok/miss pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && (hit_ok || miss)) begin
            if (q.size() == 0) begin
                chk("unexpected_event", 1, 0);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("ev_hit_ok", int'(hit_ok), int'(e.is_hit));
                chk("ev_miss", int'(miss), int'(!e.is_hit));
                chk("ev_score", int'(score), int'(e.score));
                chk("ev_lives", int'(lives), int'(e.lives));
                chk("ev_game_over", int'(game_over), int'(e.go));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; box_valid = 1'b0; hit_valid = 1'b0;
        box_in = 3'd0; hit_box = 3'd0;
        #1;
        chk("rst_active_box", int'(active_box), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_lives", int'(lives), 0);
        chk("rst_flags", int'({hit_ok, miss, game_over, busy}), 0);
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("idle_busy", int'(busy), 0);

        // Start, then box 3 lights one cycle later.
        pulse_start();
        chk("wait_busy", int'(busy), 1);
        chk("wait_active", int'(active_box), 0);
        give_box(3'd3);
        chk("show3_active", int'(active_box), 3);
        chk("show3_busy", int'(busy), 1);
        chk("show3_lives", int'(lives), 3);
        chk("show3_score", int'(score), 0);

        // Correct hit on the 4th SHOW cycle.
        cyc(3);
        expect_ev(1'b1, 1, 3, 1'b0);
        give_hit(3'd3);
        chk("hit_ok_pulse", int'(hit_ok), 1);
        chk("hit_score", int'(score), 1);
        for (int i = 0; i < 4; i++) begin
            chk("gap_active", int'(active_box), 0);
            if (i == 1) chk("hit_ok_width", int'(hit_ok), 0);
            cyc(1);
        end

        // Back in WAIT_BOX: box 4 times out exactly 8 cycles after lighting.
        expect_ev(1'b0, 1, 2, 1'b0);
        give_box(3'd4);
        chk("show4_active", int'(active_box), 4);
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            chk("timeout_early_miss", int'(miss), 0);
            chk("timeout_active", int'(active_box), 4);
        end
        cyc(1);
        chk("timeout_miss", int'(miss), 1);
        chk("timeout_lives", int'(lives), 2);
        chk("timeout_active_off", int'(active_box), 0);
        give_box(3'd5);  // ignored in GAP
        chk("gap_box_ignored", int'(active_box), 0);
        chk("miss_width", int'(miss), 0);
        cyc(3);
        chk("back_wait_active", int'(active_box), 0);
        chk("back_wait_busy", int'(busy), 1);

        // Invalid box codes are ignored.
        box_valid = 1'b1; box_in = 3'd0;
        cyc(1);
        chk("box0_ignored", int'(active_box), 0);
        box_in = 3'd7;
        cyc(1);
        chk("box7_ignored", int'(active_box), 0);
        box_in = 3'd2;
        cyc(1);
        box_valid = 1'b0;
        chk("box2_lit", int'(active_box), 2);

        // Correct hit in the same cycle the window expires.
        cyc(7);
        expect_ev(1'b1, 2, 2, 1'b0);
        give_hit(3'd2);
        chk("edge_hit_ok", int'(hit_ok), 1);
        chk("edge_miss", int'(miss), 0);
        chk("edge_lives", int'(lives), 2);
        chk("edge_score", int'(score), 2);
        cyc(4);

        // Reset in the middle of SHOW takes effect without a clock edge.
        give_box(3'd3);
        cyc(2);
        chk("pre_rst_active", int'(active_box), 3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_active", int'(active_box), 0);
        chk("async_rst_score", int'(score), 0);
        chk("async_rst_lives", int'(lives), 0);
        chk("async_rst_flags", int'({hit_ok, miss, game_over, busy}), 0);
        #2 rst = 1'b0;
        cyc(1);

        // Three wrong hits end the game.
        pulse_start();
        for (int n = 0; n < 3; n++) begin
            give_box(3'd5);
            chk("wrong_active", int'(active_box), 5);
            expect_ev(1'b0, 0, 2 - n, (n == 2));
            give_hit(3'd2);
            chk("wrong_lives", int'(lives), 2 - n);
            if (n < 2) cyc(4);
        end
        chk("over_flag", int'(game_over), 1);
        chk("over_active", int'(active_box), 0);
        chk("over_busy", int'(busy), 0);
        cyc(2);
        chk("over_hold", int'(game_over), 1);
        pulse_start();
        chk("restart_score", int'(score), 0);
        chk("restart_lives", int'(lives), 3);
        chk("restart_over", int'(game_over), 0);
        chk("restart_busy", int'(busy), 1);

        cyc(2);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bash_round_ctrl.md
Name: bash_round_ctrl

Overview:
- Game-round controller downstream of the random box selector.
- Consumes the random box number (2..5) and a new-box strobe, and presents the chosen target box to the VGA drawing stage for a fixed hit window.
- Judges player hits against that box, keeps score and lives, and signals game over.
- Sits between the box selector and the VGA/score-display logic.

Parameters:
- WINDOW_CYCLES, 37500000, clock cycles a target box stays lit (0.75 s at 50 MHz); must be >= 2.
- GAP_CYCLES, 12500000, blank cycles between rounds; must be >= 1.
- START_LIVES, 3, lives loaded at game start; range 1..3.
- SCORE_W, 8, score counter width.

Ports:
- CLOCK_50  in  1  system clock, all logic on the rising edge.
- reset_signal  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; starts or restarts a game.
- box_valid  in  1  one-cycle strobe; box_in holds a new random box.
- box_in  in  3  random box number from the selector; valid codes are 2..5.
- hit_valid  in  1  one-cycle strobe; the player struck hit_box.
- hit_box  in  3  box number struck by the player.
- active_box  out  3  box to draw; 0 means none lit.
- score  out  SCORE_W  hits this game.
- lives  out  2  remaining lives.
- hit_ok  out  1  one-cycle pulse on a correct hit.
- miss  out  1  one-cycle pulse on a wrong hit or timeout.
- game_over  out  1  high while in OVER.
- busy  out  1  high in WAIT_BOX, SHOW or GAP.

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is reset_signal, asynchronous and active-high.
- Reset values: state=IDLE, active_box=0, score=0, lives=0, hit_ok=0, miss=0, game_over=0, busy=0, timer=0. Reset asserted mid-round aborts the round immediately.
- Outputs: all outputs are registered. hit_ok and miss are exactly one cycle wide.
- IDLE:
  - Outputs quiet.
  - start=1 -> WAIT_BOX next cycle, with score<=0 and lives<=START_LIVES.
- WAIT_BOX:
  - active_box=0.
  - box_valid=1 with box_in in 2..5 -> latch box_in, set timer<=WINDOW_CYCLES-1, go to SHOW.
  - box_valid with box_in outside 2..5 is ignored and the block stays in WAIT_BOX.
  - Repeating the previous box is allowed.
- SHOW:
  - active_box = latched box, valid from the cycle after the box_valid sample (1-cycle latency).
  - Timer decrements by 1 each cycle.
  - hit_valid with hit_box==latched box: score+1 (saturates at 2^SCORE_W-1, no wrap), hit_ok=1 next cycle, go to GAP.
  - hit_valid with hit_box!=latched box: miss=1, lives-1, go to GAP if the new lives>0, else OVER.
  - Timer==0 with no hit: miss=1, lives-1, same GAP/OVER rule.
  - A correct hit in the same cycle as timer==0 counts as a hit.
  - box_valid is ignored in SHOW.
- GAP:
  - active_box=0; timer loaded with GAP_CYCLES-1 on entry.
  - hit_valid and box_valid are ignored.
  - Timer==0 -> WAIT_BOX.
- OVER:
  - game_over=1, active_box=0, score holds its final value.
  - start -> WAIT_BOX with the same init as from IDLE.
- start pulses in WAIT_BOX, SHOW or GAP are ignored.
- busy=1 in WAIT_BOX, SHOW and GAP.
- Priority within one cycle: reset > hit_valid > timer expiry > box_valid.
- lives never underflows: the decrement happens only when lives>0.

Test Plan:
(bench parameters: WINDOW_CYCLES=8, GAP_CYCLES=4, START_LIVES=3, SCORE_W=8)
- Reset then start, then box_valid with box_in=3 -> next cycle active_box=3, busy=1, lives=3, score=0.
- In SHOW with box 3, hit_valid with hit_box=3 on the 4th cycle -> hit_ok pulse for 1 cycle, score=1, active_box=0 for 4 cycles, then WAIT_BOX.
- Box 4 shown with no hit -> miss pulses exactly 8 cycles after active_box rose, lives=2. A box_valid during the following GAP is ignored (active_box stays 0).
- Three consecutive wrong hits (hit_box=2 against box 5) -> lives 2, 1, 0, then game_over=1 and active_box=0. A start pulse then gives score=0, lives=3, game_over=0.
- box_valid with box_in=0, then box_in=7 -> stays in WAIT_BOX with active_box=0. A following box_in=2 lights box 2.
- Correct hit_valid in the same cycle as timer expiry -> hit_ok=1, miss=0, lives unchanged. Separately: reset asserted mid-SHOW -> all outputs 0 immediately, without waiting for a clock edge.
